clk_divider_bank: RTL
=====================

# clk_divider_bank

Multi-channel, runtime-programmable clock/tick generator; successor to the single fixed-ratio divider used on the board-level top. Each of NUM_CH channels divides clk_in by a per-channel programmable count and produces either a 50 % square wave or a one-cycle strobe, plus a tick pulse for synchronous logic. Sits between the board clock and the slow-domain logic: display scan, debounce, and the single-step CPU clock.

## Interface
- NUM_CH, 4: number of independent channels (≥1).
- CNT_W, 26: counter and half-period width.
- DEFAULT_HALF, 49_999_999: active half-period after reset (1 Hz square wave at 100 MHz).
- CH_W, $clog2(NUM_CH) (min 1): channel-select width, derived.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable, sampled each edge.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_ch  in  CH_W  target channel; writes with cfg_ch ≥ NUM_CH are ignored.
- cfg_half  in  CNT_W  new half-period value H.
- cfg_mode  in  1  0 = toggle (square wave), 1 = pulse (strobe).
- clk_out  out  NUM_CH  divided output per channel, registered.
- tick  out  NUM_CH  one-cycle pulse at every terminal count, registered.

## Operation
- Per-channel state: cnt[CNT_W], half_act, mode_act, half_shd, mode_shd, pend.
- Reset (reset low, asynchronous): cnt=0, clk_out=0, tick=0, half_act=half_shd=DEFAULT_HALF, mode_act=mode_shd=toggle, pend=0.
- Config write (cfg_we=1, valid cfg_ch):
  - Always writes half_shd/mode_shd; a later write overwrites an earlier unapplied one, so the last write wins.
  - Channel enabled: pend←1. Values apply at the next terminal count.
  - Channel disabled: half_act/mode_act load on the same edge; pend stays 0.
- Enabled channel: cnt increments each edge. Terminal when cnt==half_act. On the terminal edge:
  - cnt←0 and tick←1 for one cycle.
  - Toggle mode: clk_out←~clk_out.
  - Pulse mode: clk_out←1 for one cycle, otherwise 0.
  - If pend: half_act←half_shd, mode_act←mode_shd, pend←0.
  - A write that lands on the terminal edge updates the shadow and sets pend. The old shadow (if pend was already set) is applied now; the new value applies at the following terminal.
- Disabled channel (ch_en[i]=0): cnt←0, clk_out←0, tick←0 on the next edge. Shadow contents are retained.
- Mode change from toggle to pulse or back takes effect at a terminal edge. clk_out follows the new mode's rule from that edge.
- H=0 boundary cases:
  - Toggle: clk_out toggles every cycle (clk_in/2).
  - Pulse: clk_out and tick held constantly high while enabled.
- cnt never exceeds half_act, so no wrap-around handling is needed. An H of 2^CNT_W−1 is legal.

## Timing
- Toggle period = 2·(H+1) cycles, duty exactly 50 %. tick period = H+1 cycles.
- Pulse period = H+1 cycles, high for 1 cycle.
- Enable latency: ch_en rises and is first sampled at edge k. The first terminal is at edge k+H, so tick and clk_out change after H+1 enabled edges.
- Disable latency: outputs are 0 after the first edge on which ch_en[i]=0 is sampled.
- Reset release: counting begins on the first edge with reset high and ch_en high.
- No combinational path from inputs to outputs.

## Structure
- Package clk_div_pkg holds:
  - the mode constants MODE_TOGGLE=1'b0 and MODE_PULSE=1'b1;
  - the CNT_W default;
  - the clog2-min-1 helper used for CH_W.
- Sub-module clk_div_channel holds one channel's counter, shadow/pend logic and output registers. Its ports are clk_in, reset, en, we, half, mode, clk_out, tick.
- The top decodes cfg_ch into per-channel we and instantiates NUM_CH channels in a generate loop.

## Test plan
Bench instance: NUM_CH=3, CNT_W=8, DEFAULT_HALF=3.
- Reset, then hold ch_en=3'b001 → clk_out[0] has period 8 and is high 4 cycles; tick[0] fires every 4 cycles; channels 1 and 2 stay 0.
- With ch1 disabled, write H=0 toggle, then enable → clk_out[1] toggles every cycle. Then write pulse H=0 → after the next terminal, clk_out[1] and tick[1] are constantly 1.
- With ch2 running at H=3, write H=1 at cnt=1 → the current half-period stays 4 cycles and subsequent half-periods are 2 cycles. Writing H=5 then H=6 before the boundary → 7-cycle half-periods. A write coincident with the terminal applies one boundary later.
- Write with cfg_ch=3 → no channel changes.
- Drop ch_en[0] mid-period → clk_out[0]=0 the next cycle. Re-enable → the first toggle comes after 4 edges.
- Assert reset mid-count with clk_out high → all outputs 0 immediately (asynchronous). After release, the active H is back to 3 and any pending writes are discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int CNT_W_DEF = 26;

  // Select width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_divider_bank_if.sv
// Run-enable, configuration and output bundle of the divider bank.
interface clk_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = clk_div_pkg::CNT_W_DEF
);
  import clk_div_pkg::*;

  localparam int CH_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_mode;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  modport master (
    output ch_en, cfg_we, cfg_ch, cfg_half, cfg_mode,
    input  clk_out, tick
  );

  modport slave (
    input  ch_en, cfg_we, cfg_ch, cfg_half, cfg_mode,
    output clk_out, tick
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: up-counter with terminal compare, shadowed
// half-period/mode that swap in at the terminal edge while running.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = 49_999_999
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] half,
  input  logic             mode,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] half_shd;
  logic             mode_act;
  logic             mode_shd;
  logic             pend;
  logic             terminal;
  logic             mode_nxt;

  assign terminal = (cnt == half_act);
  // The mode in force from the terminal edge on decides that edge's output.
  assign mode_nxt = pend ? mode_shd : mode_act;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      half_act <= HALF_RST;
      half_shd <= HALF_RST;
      mode_act <= MODE_TOGGLE;
      mode_shd <= MODE_TOGGLE;
      pend     <= 1'b0;
    end else if (!en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (we) begin
        half_shd <= half;
        mode_shd <= mode;
        half_act <= half;
        mode_act <= mode;
        pend     <= 1'b0;
      end
    end else begin
      if (terminal) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (mode_nxt == MODE_PULSE) ? 1'b1 : ~clk_out;
        if (pend) begin
          half_act <= half_shd;
          mode_act <= mode_shd;
          pend     <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (mode_act == MODE_PULSE) clk_out <= 1'b0;
      end
      // A write on the terminal edge re-arms pend for the following terminal.
      if (we) begin
        half_shd <= half;
        mode_shd <= mode;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of independently programmable clock/tick dividers driven from clk_in.
module clk_divider_bank
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = 49_999_999
) (
  input  logic              clk_in,
  input  logic              reset,
  clk_divider_bank_if.slave bus
);

  localparam int CH_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] ch_we;
  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] tick_v;

  // Out-of-range channel numbers match no decode and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (bus.ch_en[i]),
      .we      (ch_we[i]),
      .half    (bus.cfg_half),
      .mode    (bus.cfg_mode),
      .clk_out (clk_out_v[i]),
      .tick    (tick_v[i])
    );
  end

  assign bus.clk_out = clk_out_v;
  assign bus.tick    = tick_v;

endmodule
